// File: rtl/timer_slot_arbiter_pkg.sv
// Shared types and defaults for the timer slot arbiter.
// State encoding, default sizing and index-width helper.
package timer_slot_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_CNT_W    = 4;
  localparam int DEF_SLOT_LEN = 10;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_IDX_W = idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/timer_slot_arbiter_counter.sv
// Slot interval counter with clear, enable and terminal flag.
// Clear wins over enable.
module slot_counter
  import timer_slot_arbiter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SLOT_LEN = DEF_SLOT_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(SLOT_LEN));

endmodule

// File: rtl/timer_slot_arbiter.sv
// Round-robin owner of one shared interval counter.
// Each grant lasts SLOT_LEN+1 cycles, then a GAP cycle.
module timer_slot_arbiter
  import timer_slot_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SLOT_LEN = DEF_SLOT_LEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic [NUM_REQ-1:0]         done,
  output logic [CNT_W-1:0]           count,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_e             state, state_n;
  logic [NUM_REQ-1:0] gnt_n, done_n;
  logic [IW-1:0]      id_n, ptr, ptr_n, win, nxt;
  logic               own_req, tc, cnt_clr, cnt_en;
  int                 j;

  // first set request at or after ptr, wrapping
  always_comb begin
    win = '0;
    j   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (req[j]) win = j[IW-1:0];
    end
  end

  assign own_req = req[gnt_id];
  assign nxt = (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + IW'(1);

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    id_n    = gnt_id;
    done_n  = '0;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_n = RUN;
          gnt_n   = ONE << win;
          id_n    = win;
        end
      end
      RUN: begin
        if (!own_req || tc) begin
          state_n = GAP;
          gnt_n   = '0;
          ptr_n   = nxt;
          done_n  = own_req ? gnt : '0;
        end
      end
      GAP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      done   <= '0;
      ptr    <= '0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      gnt_id <= id_n;
      done   <= done_n;
      ptr    <= ptr_n;
    end
  end

  assign cnt_en  = (state == RUN);
  assign cnt_clr = (state != RUN) || (state_n != RUN);

  slot_counter #(
    .CNT_W   (CNT_W),
    .SLOT_LEN(SLOT_LEN)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(count),
    .tc   (tc)
  );

  assign busy = (state != IDLE);

endmodule
